// File: rtl/fpu_pkg.sv
// Shared encodings and field widths for the single-precision add/subtract unit.
package fpu_pkg;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int SIG_W   = FRAC_W + 1;
  localparam int EXT_W   = 27;
  localparam int SUM_W   = EXT_W + 1;
  localparam int BIAS    = 127;
  localparam int EXP_INF = 2 * BIAS + 1;
  localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(EXP_INF);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UNPACK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_e;
endpackage

// File: rtl/fp_lzc.sv
// Leading-zero count of the 28-bit raw sum; an all-zero input reports 28.
module fp_lzc
  import fpu_pkg::*;
(
  input  logic [SUM_W-1:0] in_i,
  output logic [4:0]       cnt_o
);
  always_comb begin
    cnt_o = 5'(SUM_W);
    // Scanning upward lets the highest set bit win.
    for (int i = 0; i < SUM_W; i++) begin
      if (in_i[i]) cnt_o = 5'(SUM_W - 1 - i);
    end
  end
endmodule

// File: rtl/fpu_addsub.sv
// Multi-cycle IEEE-754 single add/subtract, flush-to-zero, round-to-nearest-even.
// One pipeline stage per FSM state; result is written back through we/wa/wd.
module fpu_addsub
  import fpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SCALE = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SCALE-1:0] dst,
  output logic             busy,
  output logic             we,
  output logic [SCALE-1:0] wa,
  output logic [WIDTH-1:0] wd
);
  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, wd_q, spec_val_q, spec_val_d, res_d;
  logic             op_q, spec_q, spec_d;
  logic [SCALE-1:0] dst_q;
  logic             sa_q, sb_q, sa_d, sb_d, sl_q, sl_d, sub_q, sub_d, zero_q, zero_d;
  logic [EXP_W-1:0] ea_q, eb_q, ea_d, eb_d, el_q, el_d;
  logic [SIG_W-1:0] ma_q, mb_q, ma_d, mb_d;
  logic [EXT_W-1:0] xl_q, xs_q, xl_d, xs_d, mant_q, mant_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic signed [9:0] exp_q, exp_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_UNPACK;
      S_UNPACK: state_d = S_ALIGN;
      S_ALIGN:  state_d = S_ADD;
      S_ADD:    state_d = S_NORM;
      S_NORM:   state_d = S_ROUND;
      S_ROUND:  state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Unpack: flush subnormals, fold op into b's sign, decide special results early.
  logic [FRAC_W-1:0] fa, fb;
  logic nan_any, inf_a, inf_b;
  always_comb begin
    fa      = a_q[FRAC_W-1:0];
    fb      = b_q[FRAC_W-1:0];
    ea_d    = a_q[FRAC_W +: EXP_W];
    eb_d    = b_q[FRAC_W +: EXP_W];
    sa_d    = a_q[WIDTH-1];
    sb_d    = b_q[WIDTH-1] ^ op_q;
    ma_d    = (ea_d == '0) ? '0 : {1'b1, fa};
    mb_d    = (eb_d == '0) ? '0 : {1'b1, fb};
    nan_any = (ea_d == EXP_MAX && fa != '0) || (eb_d == EXP_MAX && fb != '0);
    inf_a   = (ea_d == EXP_MAX) && (fa == '0);
    inf_b   = (eb_d == EXP_MAX) && (fb == '0);
    spec_d  = nan_any | inf_a | inf_b;
    if (nan_any || (inf_a && inf_b && (sa_d != sb_d))) spec_val_d = QNAN;
    else if (inf_a) spec_val_d = {sa_d, EXP_MAX, {FRAC_W{1'b0}}};
    else            spec_val_d = {sb_d, EXP_MAX, {FRAC_W{1'b0}}};
  end

  // Align: larger magnitude first, smaller shifted right with guard/round/sticky.
  logic             a_big;
  logic [EXP_W-1:0] es, diff;
  logic [SIG_W-1:0] ml, ms;
  logic [EXT_W-1:0] ext_s, shr, lost_mask;
  always_comb begin
    a_big     = {ea_q, ma_q} >= {eb_q, mb_q};
    el_d      = a_big ? ea_q : eb_q;
    es        = a_big ? eb_q : ea_q;
    ml        = a_big ? ma_q : mb_q;
    ms        = a_big ? mb_q : ma_q;
    sl_d      = a_big ? sa_q : sb_q;
    sub_d     = sa_q ^ sb_q;
    diff      = el_d - es;
    xl_d      = {ml, 3'b000};
    ext_s     = {ms, 3'b000};
    shr       = ext_s >> diff;
    lost_mask = (EXT_W'(1) << diff) - EXT_W'(1);
    if (diff >= 8'd26) xs_d = {{(EXT_W-1){1'b0}}, |ms};
    else               xs_d = {shr[EXT_W-1:1], shr[0] | (|(ext_s & lost_mask))};
  end

  assign sum_d = sub_q ? ({1'b0, xl_q} - {1'b0, xs_q}) : ({1'b0, xl_q} + {1'b0, xs_q});

  logic [4:0] lz;
  fp_lzc u_lzc (
    .in_i  (sum_q),
    .cnt_o (lz)
  );

  // Normalize: the hidden bit belongs at bit 26; bit 27 is the adder carry.
  always_comb begin
    zero_d = (sum_q == '0);
    if (sum_q[SUM_W-1]) begin
      mant_d = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
      exp_d  = $signed({2'b00, el_q}) + 10'sd1;
    end else begin
      mant_d = sum_q[EXT_W-1:0] << (lz - 5'd1);
      exp_d  = $signed({2'b00, el_q}) - $signed({5'b00000, lz}) + 10'sd1;
    end
  end

  logic              rnd_up;
  logic [SIG_W:0]    rnd;
  logic [FRAC_W-1:0] frac_r;
  logic signed [9:0] exp_r;
  always_comb begin
    rnd_up = mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]);
    rnd    = {1'b0, mant_q[EXT_W-1:3]} + {{SIG_W{1'b0}}, rnd_up};
    frac_r = rnd[SIG_W] ? rnd[SIG_W-1:1] : rnd[FRAC_W-1:0];
    exp_r  = exp_q + $signed({9'b0, rnd[SIG_W]});
    if (spec_q)                     res_d = spec_val_q;
    else if (zero_q)                res_d = {~sub_q & sl_q, {(WIDTH-1){1'b0}}};
    else if (exp_r >= 10'(EXP_INF)) res_d = {sl_q, EXP_MAX, {FRAC_W{1'b0}}};
    else if (exp_r <= 10'sd0)       res_d = {sl_q, {(WIDTH-1){1'b0}}};
    else                            res_d = {sl_q, exp_r[EXP_W-1:0], frac_r};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      {a_q, b_q, op_q, dst_q, wd_q} <= '0;
      {sa_q, sb_q, ea_q, eb_q, ma_q, mb_q, spec_q, spec_val_q} <= '0;
      {sl_q, sub_q, el_q, xl_q, xs_q, sum_q, mant_q, exp_q, zero_q} <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        S_IDLE: if (start) begin
          a_q   <= a;
          b_q   <= b;
          op_q  <= op;
          dst_q <= dst;
        end
        S_UNPACK: begin
          {sa_q, sb_q, ea_q, eb_q, ma_q, mb_q} <= {sa_d, sb_d, ea_d, eb_d, ma_d, mb_d};
          spec_q     <= spec_d;
          spec_val_q <= spec_val_d;
        end
        S_ALIGN: {sl_q, sub_q, el_q, xl_q, xs_q} <= {sl_d, sub_d, el_d, xl_d, xs_d};
        S_ADD:   sum_q <= sum_d;
        S_NORM:  {mant_q, exp_q, zero_q} <= {mant_d, exp_d, zero_d};
        S_ROUND: wd_q <= res_d;
        default: ;
      endcase
    end
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign we   = (state_q == S_DONE);
  assign wa   = dst_q;
  assign wd   = wd_q;
endmodule

// File: tb/tb_fpu_addsub.sv
// Randomized bench for fpu_addsub against an exact-integer reference of IEEE add/sub.
module tb_fpu_addsub;
  logic        clk, rst, start, op, busy, we;
  logic [31:0] a, b, wd;
  logic [4:0]  dst, wa;
  int checks = 0;
  int failures = 0;

  fpu_addsub #(.WIDTH(32), .SCALE(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .dst(dst),
    .busy(busy), .we(we), .wa(wa), .wd(wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  // Exact sum as a wide integer in units of 2^-149, then one RNE rounding to 24 bits.
  function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y, input logic sub);
    logic sx, sy, sg;
    int ex, ey, p, sh, e;
    logic [22:0] fx, fy;
    logic [299:0] vx, vy, s, keep, rem, half;
    sx = x[31]; sy = y[31] ^ sub;
    ex = int'(x[30:23]); ey = int'(y[30:23]);
    fx = x[22:0]; fy = y[22:0];
    if ((ex == 255 && fx != 0) || (ey == 255 && fy != 0)) return 32'h7FC00000;
    if (ex == 255 && ey == 255) return (sx == sy) ? {sx, 8'hFF, 23'h0} : 32'h7FC00000;
    if (ex == 255) return {sx, 8'hFF, 23'h0};
    if (ey == 255) return {sy, 8'hFF, 23'h0};
    vx = (ex == 0) ? '0 : (300'({1'b1, fx}) << (ex - 1));
    vy = (ey == 0) ? '0 : (300'({1'b1, fy}) << (ey - 1));
    if (sx == sy)      begin s = vx + vy; sg = sx; end
    else if (vx >= vy) begin s = vx - vy; sg = sx; end
    else               begin s = vy - vx; sg = sy; end
    if (s == '0) return (sx == sy) ? {sx, 31'h0} : 32'h0;
    p = 0;
    for (int i = 0; i < 300; i++) if (s[i]) p = i;
    keep = s;
    if (p > 23) begin
      sh   = p - 23;
      keep = s >> sh;
      rem  = s & ((300'd1 << sh) - 300'd1);
      half = 300'd1 << (sh - 1);
      if (rem > half || (rem == half && keep[0])) keep = keep + 300'd1;
      if (keep[24]) begin keep = keep >> 1; p = p + 1; end
    end
    e = p - 22;
    if (e >= 255) return {sg, 8'hFF, 23'h0};
    if (e <= 0) return {sg, 31'h0};
    return {sg, 8'(e), keep[22:0]};
  endfunction

  function automatic logic [31:0] rand_operand();
    logic s;
    s = 1'($urandom);
    case ($urandom_range(0, 24))
      0:       return {s, 31'h0};
      1:       return {s, 8'hFF, 23'h0};
      2:       return {s, 8'hFF, 23'($urandom_range(1, 8388607))};
      3:       return {s, 8'h00, 23'($urandom_range(1, 8388607))};
      4:       return {s, 8'hFE, 23'($urandom)};
      default: return {s, 8'($urandom_range(1, 254)), 23'($urandom)};
    endcase
  endfunction

  // Issue one op, scramble inputs after accept, and watch 8 cycles after the accepting edge.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                       input logic [4:0] tdst, input logic [31:0] expv, input bit repulse);
    int lat, pulses, busy_bad;
    logic [31:0] wd_seen;
    logic [4:0]  wa_seen;
    lat = 0; pulses = 0; busy_bad = 0; wd_seen = 'x; wa_seen = 'x;
    @(negedge clk);
    a = ta; b = tb; op = top; dst = tdst; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = ~top; dst = 5'($urandom);
    for (int k = 1; k <= 8; k++) begin
      if (k == 2 && repulse) start = 1'b1;
      if (k == 3) start = 1'b0;
      if (we) begin
        pulses++;
        if (lat == 0) begin lat = k; wd_seen = wd; wa_seen = wa; end
      end
      if (k <= 5 && !busy) busy_bad++;
      if (k >= 6 && busy) busy_bad++;
      @(posedge clk); #1;
    end
    check_eq("latency", lat, 6);
    check_eq("we_pulses", pulses, 1);
    check_eq("busy_window", busy_bad, 0);
    check_eq("wa", wa_seen, tdst);
    check_eq("wd", wd_seen, expv);
    $display("txn a=%h b=%h op=%0d dst=%0d wd=%h expected=%h", ta, tb, top, tdst, wd_seen, expv);
  endtask

  task automatic reset_mid_add();
    int pulses;
    pulses = 0;
    @(negedge clk);
    a = 32'h3F800000; b = 32'h40000000; op = 1'b0; dst = 5'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_we", we, 0);
    check_eq("rst_wa", wa, 0);
    check_eq("rst_wd", wd, 0);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (we) pulses++;
    end
    check_eq("rst_no_we", pulses, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rop;
    int          ex;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; dst = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", busy, 0);
    check_eq("reset_we", we, 0);
    check_eq("reset_wa", wa, 0);
    check_eq("reset_wd", wd, 0);
    @(negedge clk); rst = 1'b0;

    do_op(32'h3F000000, 32'h3E999999, 1'b0, 5'd4, 32'h3F4CCCCC, 1'b0);
    do_op(32'h3F800000, 32'h40000000, 1'b0, 5'd1, 32'h40400000, 1'b0);
    do_op(32'h3F68F5C2, 32'h3F68F5C2, 1'b1, 5'd2, 32'h00000000, 1'b0);
    do_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'd3, 32'h7F800000, 1'b0);
    do_op(32'h7F800000, 32'h7F800000, 1'b1, 5'd5, 32'h7FC00000, 1'b0);
    do_op(32'h80000000, 32'h80000000, 1'b0, 5'd6, 32'h80000000, 1'b0);
    do_op(32'h3F800000, 32'h7F800000, 1'b1, 5'd7, 32'hFF800000, 1'b0);
    do_op(32'h7FC12345, 32'h3F800000, 1'b0, 5'd8, 32'h7FC00000, 1'b0);
    do_op(32'h00400000, 32'h3F800000, 1'b0, 5'd10, 32'h3F800000, 1'b0);
    do_op(32'h3F800000, 32'h40000000, 1'b0, 5'd11, 32'h40400000, 1'b1);
    reset_mid_add();
    do_op(32'h3F800000, 32'h40000000, 1'b0, 5'd12, 32'h40400000, 1'b0);

    for (int n = 0; n < 300; n++) begin
      ra  = rand_operand();
      rop = 1'($urandom);
      case ($urandom_range(0, 9))
        0: rb = ra;
        1: rb = {~ra[31], ra[30:0]};
        2, 3, 4, 5: begin
          ex = int'(ra[30:23]) + $urandom_range(0, 60) - 30;
          if (ex < 1) ex = 1;
          if (ex > 254) ex = 254;
          rb = {1'($urandom), 8'(ex), 23'($urandom)};
        end
        default: rb = rand_operand();
      endcase
      do_op(ra, rb, rop, 5'($urandom), ref_add(ra, rb, rop), n % 17 == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_addsub.md
FPU_ADDSUB -- requirements
Module: fpu_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width (IEEE-754 single: [31] sign, [30:23] exp, [22:0] frac).
REQ-002 SHALL have parameter SCALE, default 5, register-address width, matching the FP register file.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-006 SHALL have port op  input  1  0 = a+b, 1 = a-b.
REQ-007 SHALL have ports a, b  input  WIDTH each  operands, driven from register-file read ports rd0/rd1.
REQ-008 SHALL have port dst  input  SCALE  destination FP register.
REQ-009 SHALL have port busy  output  1  high from accept through the ROUND cycle.
REQ-010 SHALL have port we  output  1  one-cycle write-enable pulse to the register file.
REQ-011 SHALL have port wa  output  SCALE  write address, valid while we=1.
REQ-012 SHALL have port wd  output  WIDTH  result, valid while we=1, held until the next accept.

Function
REQ-013 SHALL latch a, b, op and dst on the accepting edge (IDLE, start=1); later input changes SHALL NOT affect the result.
REQ-014 SHALL sequence IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE, one cycle per state.
REQ-015 SHALL assert we exactly in DONE: fixed latency of 6 cycles from the accepting edge to we=1.
REQ-016 SHALL ignore start outside IDLE; back-to-back issue is possible on the cycle after DONE.
REQ-017 SHALL treat subtraction as addition with b's sign inverted.
REQ-018 UNPACK SHALL flush subnormal operands (exp=0) to signed zero and classify zero/inf/NaN.
REQ-019 ALIGN SHALL swap operands so the larger magnitude is first, then right-shift the smaller 24-bit significand by the exponent difference into a 27-bit field (guard, round, sticky); shifts >=26 SHALL leave only sticky.
REQ-020 ADD SHALL add or subtract magnitudes in 28 bits; result sign SHALL be the larger operand's sign.
REQ-021 NORM SHALL right-shift 1 on carry-out (OR-ing the lost bit into sticky) or left-shift by the leading-zero count, adjusting the exponent in one cycle.
REQ-022 ROUND SHALL apply round-to-nearest-even; mantissa overflow from rounding SHALL increment the exponent.
REQ-023 Exponent >=255 after rounding SHALL give signed infinity; exponent <=0 SHALL give signed zero (flush-to-zero).
REQ-024 Exact zero difference SHALL give +0 (0x00000000); (-0)+(-0) SHALL give 0x80000000.
REQ-025 Any NaN operand, or inf-inf with opposite effective signs, SHALL give 0x7FC00000; inf plus finite SHALL give that inf.
REQ-026 wa SHALL equal the latched dst.

Reset
REQ-027 On rst=1, state SHALL go to IDLE immediately, with busy=0, we=0, wa=0, wd=0, regardless of current state.
REQ-028 Reset mid-operation SHALL discard the in-flight result; no we pulse SHALL follow.

Structure
REQ-029 Package fpu_pkg SHALL hold state encoding, field-width constants (EXP_W=8, FRAC_W=23, EXT_W=27), bias 127 and QNAN=32'h7FC00000.
REQ-030 The leading-zero count SHALL be a sub-module fp_lzc (28-bit input, 5-bit count).

Verification
REQ-031 a=0x3F000000, b=0x3E999999, op=0, dst=4 -> we at cycle 6, wa=4, wd=0x3F4CCCCC (tie rounded to even).
REQ-032 a=0x3F800000, b=0x40000000, op=0 -> wd=0x40400000; a=0x3F68F5C2, b=0x3F68F5C2, op=1 -> wd=0x00000000.
REQ-033 a=b=0x7F7FFFFF, op=0 -> wd=0x7F800000; a=b=0x7F800000, op=1 -> wd=0x7FC00000.
REQ-034 Start accepted, then start re-pulsed during ALIGN with different operands -> exactly one we pulse with the first operands' result; busy stays high through ROUND.
REQ-035 rst asserted during ADD -> busy=0 and we=0 immediately; no we in the following 10 cycles; a fresh start then completes normally.
